// File: rtl/glyph_plotter.sv
// Character glyph plotter: expands a 16x8 glyph into per-pixel writes on a
// 160x120 screen (20x7 text cells) and services full-screen clear requests.
module glyph_plotter #(
    parameter logic [2:0] FG_COLOUR   = 3'b111,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter bit         TRANSPARENT = 1'b0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CHAR_VALID,
    output logic         CHAR_READY,
    input  logic [6:0]   CHAR,
    input  logic [4:0]   COL,
    input  logic [2:0]   ROW,
    input  logic         CLEAR_REQ,
    output logic [6:0]   GLYPH_CODE,
    input  logic [127:0] GLYPH_BITS,
    output logic [7:0]   X,
    output logic [6:0]   Y,
    output logic [2:0]   COLOUR,
    output logic         PLOT,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [2:0] {IDLE, LOAD, DRAW, CLEAR, FINISH} state_t;

    state_t         state_q, state_d;
    logic           clear_pending_q, clear_pending_d;
    logic [127:0]   shreg_q, shreg_d;
    logic [6:0]     code_q, code_d;
    logic [4:0]     col_q, col_d;
    logic [2:0]     row_q, row_d;
    logic [7:0]     idx_q, idx_d;
    logic [7:0]     cx_q, cx_d;
    logic [6:0]     cy_q, cy_d;
    logic [7:0]     x_q, x_d;
    logic [6:0]     y_q, y_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           done_q, done_d;

    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q | CLEAR_REQ;
        shreg_d         = shreg_q;
        code_d          = code_q;
        col_d           = col_q;
        row_d           = row_q;
        idx_d           = idx_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        x_d             = x_q;
        y_d             = y_q;
        colour_d        = colour_q;
        plot_d          = 1'b0;
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_pending_q || CLEAR_REQ) begin
                    state_d         = CLEAR;
                    clear_pending_d = 1'b0;
                    cx_d            = '0;
                    cy_d            = '0;
                end else if (CHAR_VALID) begin
                    code_d = CHAR;
                    col_d  = COL;
                    row_d  = ROW;
                    if (COL > 5'd19 || ROW > 3'd6) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                shreg_d = GLYPH_BITS;
                idx_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                // idx 128 is a drain cycle so FINISH (and DONE) starts one edge after the last pixel.
                if (idx_q[7]) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    x_d      = {col_q, 3'b000} + {5'b00000, idx_q[2:0]};
                    y_d      = {row_q, 4'b0000} + {3'b000, idx_q[6:3]};
                    colour_d = shreg_q[127] ? FG_COLOUR : BG_COLOUR;
                    plot_d   = shreg_q[127] | ~TRANSPARENT;
                    shreg_d  = {shreg_q[126:0], 1'b0};
                    idx_d    = idx_q + 8'd1;
                end
            end
            CLEAR: begin
                if (cy_q == 7'd120) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    x_d      = cx_q;
                    y_d      = cy_q;
                    colour_d = BG_COLOUR;
                    plot_d   = 1'b1;
                    if (cx_q == 8'd159) begin
                        cx_d = '0;
                        cy_d = cy_q + 7'd1;
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= IDLE;
            clear_pending_q <= 1'b0;
            shreg_q         <= '0;
            code_q          <= '0;
            col_q           <= '0;
            row_q           <= '0;
            idx_q           <= '0;
            cx_q            <= '0;
            cy_q            <= '0;
            x_q             <= '0;
            y_q             <= '0;
            colour_q        <= '0;
            plot_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            shreg_q         <= shreg_d;
            code_q          <= code_d;
            col_q           <= col_d;
            row_q           <= row_d;
            idx_q           <= idx_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            x_q             <= x_d;
            y_q             <= y_d;
            colour_q        <= colour_d;
            plot_q          <= plot_d;
            done_q          <= done_d;
        end
    end

    assign CHAR_READY = (state_q == IDLE) & ~RESET & ~CLEAR_REQ & ~clear_pending_q;
    assign BUSY       = (state_q != IDLE);
    assign GLYPH_CODE = code_q;
    assign X          = x_q;
    assign Y          = y_q;
    assign COLOUR     = colour_q;
    assign PLOT       = plot_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Scoreboard bench for glyph_plotter: an opaque and a transparent instance
// share stimulus; expected pixels are queued at request time and popped on PLOT.
module tb_glyph_plotter;

    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic         clk, rst, char_valid, clear_req;
    logic [6:0]   ch;
    logic [4:0]   col;
    logic [2:0]   row;
    logic         ready0, ready1, busy0, busy1, plot0, plot1, done0, done1;
    logic [6:0]   code0, code1;
    logic [127:0] bits0, bits1;
    logic [7:0]   x0, x1;
    logic [6:0]   y0, y1;
    logic [2:0]   colour0, colour1;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int unsigned  cyc      = 0;
    int unsigned  accept_cyc, done_cyc, release_cyc, done_before;
    int unsigned  done0_cnt = 0;
    int unsigned  plot1_cnt = 0;
    logic [17:0]  q0[$];
    logic [17:0]  q1[$];

    function automatic logic [127:0] glyph_of(input logic [6:0] code);
        case (code)
            7'd65:   glyph_of = {8'h00, 8'h10, 8'h28, 8'h44, 8'h44, 8'h7C, 8'h44, 8'h44, 64'h0};
            7'd49:   glyph_of = {8'h00, 8'h10, 8'h30, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h38, 56'h0};
            default: glyph_of = {16{code, 1'b1}};
        endcase
    endfunction

    function automatic logic [17:0] mk(input int x, input int y, input logic [2:0] c);
        logic [31:0] xv, yv;
        xv = x;
        yv = y;
        return {xv[7:0], yv[6:0], c};
    endfunction

    assign bits0 = glyph_of(code0);
    assign bits1 = glyph_of(code1);

    glyph_plotter u_dut (
        .CLK(clk), .RESET(rst), .CHAR_VALID(char_valid), .CHAR_READY(ready0),
        .CHAR(ch), .COL(col), .ROW(row), .CLEAR_REQ(clear_req),
        .GLYPH_CODE(code0), .GLYPH_BITS(bits0), .X(x0), .Y(y0),
        .COLOUR(colour0), .PLOT(plot0), .BUSY(busy0), .DONE(done0)
    );

    glyph_plotter #(.FG_COLOUR(FG), .BG_COLOUR(BG), .TRANSPARENT(1'b1)) u_dut_t (
        .CLK(clk), .RESET(rst), .CHAR_VALID(char_valid), .CHAR_READY(ready1),
        .CHAR(ch), .COL(col), .ROW(row), .CLEAR_REQ(clear_req),
        .GLYPH_CODE(code1), .GLYPH_BITS(bits1), .X(x1), .Y(y1),
        .COLOUR(colour1), .PLOT(plot1), .BUSY(busy1), .DONE(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (plot0) begin
                if (q0.size() == 0) check("extra_plot0", {31'b0, plot0}, 32'd0);
                else check("pix0", {14'b0, x0, y0, colour0}, {14'b0, q0.pop_front()});
            end
            if (plot1) begin
                plot1_cnt++;
                if (q1.size() == 0) check("extra_plot1", {31'b0, plot1}, 32'd0);
                else check("pix1", {14'b0, x1, y1, colour1}, {14'b0, q1.pop_front()});
            end
            if (done0) done0_cnt++;
        end
    end

    task automatic push_glyph(input logic [6:0] c, input int cl, input int rw);
        logic [127:0] g;
        logic [17:0]  px;
        g = glyph_of(c);
        for (int i = 0; i < 128; i++) begin
            px = mk(cl * 8 + i % 8, rw * 16 + i / 8, g[127 - i] ? FG : BG);
            q0.push_back(px);
            if (g[127 - i]) q1.push_back(px);
        end
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                q0.push_back(mk(xx, yy, BG));
                q1.push_back(mk(xx, yy, BG));
            end
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic send_char(input logic [6:0] c, input logic [4:0] cl, input logic [2:0] rw,
                             input int unsigned bound);
        char_valid = 1'b1;
        ch = c;
        col = cl;
        row = rw;
        #1;
        for (int i = 0; i < bound; i++) begin
            if (ready0) break;
            @(negedge clk);
            #1;
        end
        if (!ready0) begin
            check("accept_timeout", {31'b0, ready0}, 32'd1);
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (cl <= 5'd19 && rw <= 3'd6) push_glyph(c, int'(cl), int'(rw));
            #1;
            accept_cyc = cyc;
            char_valid = 1'b0;
        end
    endtask

    task automatic at_edge(input int unsigned k);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cyc == accept_cyc + k) return;
        end
        check("at_edge_timeout", cyc, accept_cyc + k);
    endtask

    task automatic wait_done(input int unsigned bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done0) begin
                done_cyc = cyc;
                return;
            end
        end
        check("done_timeout", {31'b0, done0}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        char_valid = 1'b0;
        clear_req = 1'b0;
        ch = '0;
        col = '0;
        row = '0;
        repeat (3) @(negedge clk);
        check("rst_plot",   {31'b0, plot0}, 32'd0);
        check("rst_done",   {31'b0, done0}, 32'd0);
        check("rst_xyc",    {14'b0, x0, y0, colour0}, 32'd0);
        check("rst_code",   {25'b0, code0}, 32'd0);
        check("rst_ready",  {31'b0, ready0}, 32'd0);
        check("rst_busy",   {31'b0, busy0}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, ready0}, 32'd1);
        @(negedge clk);

        // 'A' at cell (0,0), opaque and transparent in parallel
        send_char(7'd65, 5'd0, 3'd0, 5);
        at_edge(1);
        check("a_no_plot_e1", {31'b0, plot0}, 32'd0);
        at_edge(2);
        check("a_first_plot_e2", {31'b0, plot0}, 32'd1);
        at_edge(13);
        check("a_first_fg", {14'b0, x0, y0, colour0}, {14'b0, mk(3, 1, FG)});
        at_edge(129);
        check("a_last_plot_e129", {31'b0, plot0}, 32'd1);
        at_edge(130);
        check("a_plot_low_e130", {31'b0, plot0}, 32'd0);
        check("a_done_e130", {31'b0, done0}, 32'd1);
        check("a_ready_low_e130", {31'b0, ready0}, 32'd0);
        at_edge(131);
        check("a_done_pulse", {31'b0, done0}, 32'd0);
        check("a_ready_e131", {31'b0, ready0}, 32'd1);
        check("a_q0_drain", q0.size(), 32'd0);
        check("a_q1_drain", q1.size(), 32'd0);

        // '1' at the bottom-right cell: transparent count equals glyph popcount
        plot1_cnt = 0;
        send_char(7'd49, 5'd19, 3'd6, 5);
        wait_done(200);
        check("one_popcount", plot1_cnt, $countones(glyph_of(7'd49)));
        check("one_q0_drain", q0.size(), 32'd0);
        check("one_q1_drain", q1.size(), 32'd0);
        @(negedge clk);

        // Out-of-range requests are dropped
        send_char(7'd66, 5'd20, 3'd0, 5);
        at_edge(0);
        check("col20_done", {31'b0, done0}, 32'd1);
        at_edge(1);
        check("col20_done_pulse", {31'b0, done0}, 32'd0);
        check("col20_ready", {31'b0, ready0}, 32'd1);
        send_char(7'd66, 5'd0, 3'd7, 5);
        at_edge(0);
        check("row7_done", {31'b0, done0}, 32'd1);
        at_edge(1);
        check("row7_ready", {31'b0, ready0}, 32'd1);

        // Clear and character together: clear wins, character waits
        clear_req = 1'b1;
        char_valid = 1'b1;
        ch = 7'd66;
        col = 5'd1;
        row = 3'd1;
        #1;
        check("clr_blocks_ready", {31'b0, ready0}, 32'd0);
        push_clear();
        @(negedge clk);
        clear_req = 1'b0;
        check("clr_busy", {31'b0, busy0}, 32'd1);
        wait_done(19300);
        check("clr_last_xy", {17'b0, x0, y0}, {17'b0, 8'd159, 7'd119});
        check("clr_q0_drain", q0.size(), 32'd0);
        send_char(7'd66, 5'd1, 3'd1, 5);
        check("clr_then_accept", accept_cyc - done_cyc, 32'd2);
        wait_done(200);
        check("b_q0_drain", q0.size(), 32'd0);

        // Clear request mid-glyph: glyph completes, then clear with no ready window
        @(negedge clk);
        send_char(7'd67, 5'd5, 3'd3, 5);
        at_edge(20);
        clear_req = 1'b1;
        push_clear();
        @(negedge clk);
        clear_req = 1'b0;
        wait_done(200);
        check("e_glyph_done_ready", {31'b0, ready0}, 32'd0);
        @(negedge clk);
        check("e_idle_ready_low", {31'b0, ready0}, 32'd0);
        @(negedge clk);
        check("e_clear_busy", {31'b0, busy0}, 32'd1);
        check("e_clear_ready_low", {31'b0, ready0}, 32'd0);
        wait_done(19300);
        @(negedge clk);
        check("e_ready_after", {31'b0, ready0}, 32'd1);
        check("e_q0_drain", q0.size(), 32'd0);
        check("e_q1_drain", q1.size(), 32'd0);

        // Reset at DRAW pixel 50
        send_char(7'd65, 5'd2, 3'd2, 5);
        at_edge(52);
        done_before = done0_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("f_plot_low", {31'b0, plot0}, 32'd0);
        check("f_busy_low", {31'b0, busy0}, 32'd0);
        check("f_ready_in_rst", {31'b0, ready0}, 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        release_cyc = cyc;
        repeat (4) @(negedge clk);
        check("f_no_done", done0_cnt, done_before);
        release_cyc = cyc;
        send_char(7'd72, 5'd0, 3'd0, 5);
        check("f_first_accept", accept_cyc - release_cyc, 32'd1);
        wait_done(200);
        check("f_q0_drain", q0.size(), 32'd0);
        check("f_q1_drain", q1.size(), 32'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/glyph_plotter.md
GLYPH_PLOTTER -- requirements
Module: glyph_plotter

Interface
REQ-001 SHALL have parameter FG_COLOUR, default 3'b111: colour plotted for set glyph bits.
REQ-002 SHALL have parameter BG_COLOUR, default 3'b000: colour for clear glyph bits and for screen clear.
REQ-003 SHALL have parameter TRANSPARENT, default 0: when 1, clear glyph bits are skipped (no PLOT).
REQ-004 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-005 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port CHAR_VALID, input, 1: a character draw request is present.
REQ-007 SHALL have port CHAR_READY, output, 1: the block accepts a request this cycle.
REQ-008 SHALL have port CHAR, input, 7: ASCII code to draw.
REQ-009 SHALL have port COL, input, 5: text column, valid range 0..19.
REQ-010 SHALL have port ROW, input, 3: text row, valid range 0..6.
REQ-011 SHALL have port CLEAR_REQ, input, 1: request to fill the whole 160x120 screen with BG_COLOUR.
REQ-012 SHALL have port GLYPH_CODE, output, 7: code driven to the external character decoder.
REQ-013 SHALL have port GLYPH_BITS, input, 128: combinational decoder result; bit 127-(8r+c) is pixel row r (0..15), column c (0..7).
REQ-014 SHALL have ports X, output, 8 and Y, output, 7: pixel coordinate.
REQ-015 SHALL have port COLOUR, output, 3: pixel colour.
REQ-016 SHALL have port PLOT, output, 1: X/Y/COLOUR is a valid write this cycle.
REQ-017 SHALL have ports BUSY, output, 1 (state != IDLE) and DONE, output, 1 (one-cycle completion pulse).

Function
REQ-018 SHALL implement the states IDLE, LOAD, DRAW, CLEAR and FINISH; all outputs except CHAR_READY and BUSY are registered.
REQ-019 SHALL drive CHAR_READY = IDLE & !RESET & !CLEAR_REQ & !clear_pending.
REQ-020 SHALL accept a request on CHAR_VALID & CHAR_READY at a rising edge, latching CHAR, COL and ROW; GLYPH_CODE holds the latched CHAR until the next acceptance.
REQ-021 SHALL, for an accepted request with COL>19 or ROW>6, go IDLE->FINISH with no PLOT (request dropped).
REQ-022 SHALL, for a valid request, go IDLE->LOAD; LOAD captures GLYPH_BITS into a 128-bit shift register and goes to DRAW.
REQ-023 SHALL in DRAW emit one pixel per cycle for index i=0..127: r=i/8, c=i%8, X=COL*8+c, Y=ROW*16+r, COLOUR=FG_COLOUR if the bit is set, else BG_COLOUR.
REQ-024 SHALL assert PLOT for every DRAW pixel when TRANSPARENT=0, and only for set bits when TRANSPARENT=1; DRAW always lasts exactly 128 cycles.
REQ-025 SHALL meet this timing: acceptance at edge 0, first PLOT cycle after edge 2, last PLOT cycle after edge 129, DONE high for the cycle after edge 130, CHAR_READY high again after edge 131.
REQ-026 SHALL set a sticky clear_pending on CLEAR_REQ in any state; in IDLE, clear_pending or CLEAR_REQ wins over CHAR_VALID and enters CLEAR.
REQ-027 SHALL in CLEAR emit a raster scan X=0..159 (inner), Y=0..119 (outer), 19200 PLOTs with COLOUR=BG_COLOUR, then go to FINISH.
REQ-028 SHALL clear clear_pending on CLEAR entry; a CLEAR_REQ arriving during CLEAR re-arms it.
REQ-029 SHALL in FINISH pulse DONE for one cycle, drive PLOT=0, and return to IDLE.
REQ-030 SHALL not accept a new character while BUSY; CHAR_VALID held in that time is waited on, not lost.

Reset
REQ-031 SHALL, while RESET is high, force: state IDLE, clear_pending 0, PLOT 0, DONE 0, X 0, Y 0, COLOUR 0, GLYPH_CODE 0, shift register 0, CHAR_READY 0.
REQ-032 SHALL, on RESET mid-DRAW or mid-CLEAR, abort immediately with no further PLOT and no DONE; the first acceptance follows the first edge after release.

Verification
REQ-033 SHALL test: reset, then CHAR=65 ('A'), COL=0, ROW=0 -> 128 PLOTs; indices 0..7 are BG at Y=0; first FG at X=3,Y=1; DONE after edge 130.
REQ-034 SHALL test: CHAR=49 ('1'), COL=19, ROW=6, TRANSPARENT=1 -> PLOTs only for set bits, all with X in 152..159 and Y in 96..111; the count equals the popcount of the glyph.
REQ-035 SHALL test: COL=20 (and separately ROW=7) -> no PLOT; DONE high in the cycle after acceptance.
REQ-036 SHALL test: CLEAR_REQ and CHAR_VALID asserted together in IDLE -> 19200 BG PLOTs ending at X=159,Y=119, then DONE, then the character is accepted.
REQ-037 SHALL test: a CLEAR_REQ pulse during DRAW -> the glyph finishes, DONE pulses, and CLEAR starts without CHAR_READY going high in between.
REQ-038 SHALL test: RESET asserted at DRAW pixel 50 -> PLOT low in the same cycle, no DONE, CHAR_READY high after release.
